draw_obstacle_set: RTL and testbench

Renders N_OBST scrolling vertical obstacle pairs ("pipes") over the incoming VGA stream. Each pipe has a top and a bottom bar separated by a gap whose vertical position is pseudo-random. Positions update once per frame at the start of vertical blanking, so no tearing occurs. The block sits in the vga_if chain after the background stage and ahead of the player/sprite stage. It exports a per-pixel obstacle flag and a counter of passed obstacles for game logic.

---
 rtl/draw_obstacle_set_if.sv | 13 +
 rtl/draw_obstacle_set.sv | 169 ++++++++++++++++
 tb/tb_draw_obstacle_set.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_obstacle_set_if.sv
// vga_if: one pixel of VGA timing plus 12-bit colour, passed stage to stage.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_obstacle_set.sv
// draw_obstacle_set: overlays N_OBST scrolling pipe pairs on the vga_if stream.
// Obstacle state moves only on the vblank rising edge, so a visible frame never tears.
module draw_obstacle_set #(
  parameter int          N_OBST     = 3,
  parameter int          OBST_W     = 50,
  parameter int          GAP_H      = 150,
  parameter int          GAP_MIN    = 100,
  parameter int          GAP_MAX    = 400,
  parameter int          SPACING    = 300,
  parameter int          SPEED      = 2,
  parameter logic [11:0] COLOR      = 12'hff0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          HOR_PIXELS = 800,
  parameter int          VER_PIXELS = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        restart,
  vga_if.in           in,
  vga_if.out          out,
  output logic        obst_pix,
  output logic [15:0] passed_cnt
);

  localparam int GAP_RANGE = GAP_MAX - GAP_MIN;
  localparam logic [15:0]        LFSR_MASK  = 16'hB400;
  localparam logic signed [12:0] OBST_W13   = 13'(OBST_W);
  localparam logic signed [12:0] NEG_OBST_W = 13'(-OBST_W);
  localparam logic signed [12:0] SPEED13    = 13'(SPEED);
  localparam logic signed [12:0] SPAN13     = 13'(N_OBST * SPACING);
  localparam logic signed [12:0] GAP_H13    = 13'(GAP_H);

  if (N_OBST < 1 || N_OBST > 8) begin : g_bad_n_obst
    $error("draw_obstacle_set: N_OBST must be within 1..8");
  end
  if (GAP_MAX + GAP_H > VER_PIXELS) begin : g_bad_gap
    $error("draw_obstacle_set: GAP_MAX + GAP_H exceeds VER_PIXELS");
  end
  if (SPACING <= SPEED) begin : g_bad_spacing
    $error("draw_obstacle_set: SPACING must exceed SPEED");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("draw_obstacle_set: LFSR_SEED must be nonzero");
  end

  function automatic logic signed [12:0] init_x(input int i);
    return 13'(HOR_PIXELS + i * SPACING);
  endfunction

  function automatic logic [10:0] init_gap(input int i);
    return 11'(GAP_MIN + (i * GAP_RANGE) / N_OBST);
  endfunction

  logic signed [12:0] x_q   [N_OBST];
  logic signed [12:0] x_d   [N_OBST];
  logic signed [12:0] dec_x [N_OBST];
  logic [10:0]        gap_q [N_OBST];
  logic [10:0]        gap_d [N_OBST];
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        passed_q, passed_d;
  logic               vblnk_q;
  logic               frame_tick;
  logic [19:0]        gap_prod;
  logic [10:0]        respawn_gap;

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, vsync_q, hblnk_q;
  logic [11:0] rgb_q, rgb_d;
  logic        pix_q, pix_d;
  logic        hit;
  logic signed [12:0] h_s, v_s;

  // Restart wins over the tick for positions, but the LFSR keeps free-running on every tick.
  always_comb begin
    frame_tick  = in.vblnk & ~vblnk_q;
    lfsr_d      = lfsr_q;
    if (frame_tick)
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    gap_prod    = 20'(lfsr_q[7:0]) * 20'(GAP_RANGE);
    respawn_gap = 11'(GAP_MIN + int'(gap_prod >> 8));
    passed_d    = passed_q;
    for (int i = 0; i < N_OBST; i++) begin
      x_d[i]   = x_q[i];
      gap_d[i] = gap_q[i];
      dec_x[i] = x_q[i] - SPEED13;
      if (restart) begin
        x_d[i]   = init_x(i);
        gap_d[i] = init_gap(i);
      end else if (frame_tick && enable) begin
        if (dec_x[i] <= NEG_OBST_W) begin
          x_d[i]   = dec_x[i] + SPAN13;
          gap_d[i] = respawn_gap;
          passed_d = passed_d + 16'd1;
        end else begin
          x_d[i] = dec_x[i];
        end
      end
    end
    if (restart)
      passed_d = 16'd0;
  end

  always_comb begin
    h_s = $signed({2'b00, in.hcount});
    v_s = $signed({2'b00, in.vcount});
    hit = 1'b0;
    for (int i = 0; i < N_OBST; i++) begin
      if ((h_s >= x_q[i]) && (h_s < x_q[i] + OBST_W13) &&
          ((v_s < $signed({2'b00, gap_q[i]})) ||
           (v_s >= $signed({2'b00, gap_q[i]}) + GAP_H13)))
        hit = 1'b1;
    end
    rgb_d = in.rgb;
    pix_d = 1'b0;
    if (in.vblnk || in.hblnk) begin
      rgb_d = 12'h000;
    end else if (hit) begin
      rgb_d = COLOR;
      pix_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OBST; i++) begin
        x_q[i]   <= init_x(i);
        gap_q[i] <= init_gap(i);
      end
      lfsr_q   <= LFSR_SEED;
      passed_q <= 16'd0;
      vblnk_q  <= 1'b0;
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      rgb_q    <= 12'h000;
      pix_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_OBST; i++) begin
        x_q[i]   <= x_d[i];
        gap_q[i] <= gap_d[i];
      end
      lfsr_q   <= lfsr_d;
      passed_q <= passed_d;
      vblnk_q  <= in.vblnk;
      hcount_q <= in.hcount;
      vcount_q <= in.vcount;
      hsync_q  <= in.hsync;
      vsync_q  <= in.vsync;
      hblnk_q  <= in.hblnk;
      rgb_q    <= rgb_d;
      pix_q    <= pix_d;
    end
  end

  // The registered vblank doubles as the edge detector's history bit.
  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.vsync  = vsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vblnk  = vblnk_q;
  assign out.rgb    = rgb_q;
  assign obst_pix   = pix_q;
  assign passed_cnt = passed_q;

endmodule

// File: tb/tb_draw_obstacle_set.sv
// tb_draw_obstacle_set: scoreboard bench driving compressed two-cycle "frames"
// (one visible pixel, one vblank pixel) so hundreds of scroll steps stay cheap.
module tb_draw_obstacle_set;

  localparam int          N        = 3;
  localparam int          W        = 50;
  localparam int          GH       = 150;
  localparam int          GMIN     = 100;
  localparam int          GMAX     = 400;
  localparam int          SP       = 300;
  localparam int          SPD      = 2;
  localparam logic [11:0] COL      = 12'hff0;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        restart;
  logic        obst_pix;
  logic [15:0] passed_cnt;

  vga_if vga_in ();
  vga_if vga_out ();

  draw_obstacle_set dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .restart    (restart),
    .in         (vga_in),
    .out        (vga_out),
    .obst_pix   (obst_pix),
    .passed_cnt (passed_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] timing;
    logic [11:0] rgb;
    logic        pix;
  } sb_t;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic [11:0] rgb_in;
    logic [11:0] exp_rgb;
    logic        exp_pix;
  } vec_t;

  sb_t         sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  int          mx   [N];
  int          mgap [N];
  int          mpassed;
  logic [15:0] mlfsr;
  logic        mvb_d;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_assert++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]   = 800 + i * SP;
      mgap[i] = GMIN + (i * (GMAX - GMIN)) / N;
    end
    mpassed = 0;
    mlfsr   = SEED;
    mvb_d   = 1'b0;
  endtask

  // Reference behaviour for one clock edge, given the inputs presented before it.
  task automatic model_clock(input logic vb, input logic rs);
    logic        tick;
    logic [15:0] cur;
    int          d;
    tick = vb && !mvb_d;
    cur  = mlfsr;
    if (tick) begin
      mlfsr = mlfsr >> 1;
      if (cur[0]) mlfsr = mlfsr ^ 16'hB400;
    end
    if (rs) begin
      for (int i = 0; i < N; i++) begin
        mx[i]   = 800 + i * SP;
        mgap[i] = GMIN + (i * (GMAX - GMIN)) / N;
      end
      mpassed = 0;
    end else if (tick && enable) begin
      for (int i = 0; i < N; i++) begin
        d = mx[i] - SPD;
        if (d <= -W) begin
          mx[i]   = d + N * SP;
          mgap[i] = GMIN + ((int'(cur[7:0]) * (GMAX - GMIN)) >> 8);
          mpassed = (mpassed + 1) & 16'hffff;
        end else begin
          mx[i] = d;
        end
      end
    end
    mvb_d = vb;
  endtask

  task automatic model_pixel(input int h, input int v, input logic hb, input logic vb,
                             input logic [11:0] rgb_in, output logic [11:0] rgb_o,
                             output logic pix_o);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (h >= mx[i] && h < mx[i] + W && (v < mgap[i] || v >= mgap[i] + GH)) hit = 1'b1;
    rgb_o = rgb_in;
    pix_o = 1'b0;
    if (hb || vb) rgb_o = 12'h000;
    else if (hit) begin
      rgb_o = COL;
      pix_o = 1'b1;
    end
  endtask

  // One pixel per call: retire the previous expectation, drive, predict, advance the model.
  task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v, input logic hb,
                               input logic vb, input logic [11:0] rgb_in, input logic rs,
                               input logic use_vec, input logic [11:0] vec_rgb,
                               input logic vec_pix);
    sb_t e;
    logic [11:0] m_rgb;
    logic        m_pix;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("out_timing", {vga_out.hcount, vga_out.vcount, vga_out.hsync,
                                 vga_out.vsync, vga_out.hblnk, vga_out.vblnk}, 32'(e.timing));
      checkOutput("out_rgb", 32'(vga_out.rgb), 32'(e.rgb));
      checkOutput("obst_pix", 32'(obst_pix), 32'(e.pix));
    end
    vga_in.hcount = h;
    vga_in.vcount = v;
    vga_in.hsync  = 1'($urandom);
    vga_in.vsync  = 1'($urandom);
    vga_in.hblnk  = hb;
    vga_in.vblnk  = vb;
    vga_in.rgb    = rgb_in;
    restart       = rs;
    model_pixel(int'(h), int'(v), hb, vb, rgb_in, m_rgb, m_pix);
    e.timing = {h, v, vga_in.hsync, vga_in.vsync, hb, vb};
    e.rgb    = use_vec ? vec_rgb : m_rgb;
    e.pix    = use_vec ? vec_pix : m_pix;
    sb.push_back(e);
    model_clock(vb, rs);
  endtask

  task automatic run_frames(input int n, input int restart_at);
    for (int f = 0; f < n; f++) begin
      applyStimulus(11'($urandom_range(799)), 11'($urandom_range(599)), 1'b0, 1'b0,
                    12'($urandom), 1'b0, 1'b0, 12'h0, 1'b0);
      applyStimulus(11'($urandom_range(799)), 11'($urandom_range(599)), 1'b0, 1'b1,
                    12'($urandom), 1'(f == restart_at), 1'b0, 12'h0, 1'b0);
    end
  endtask

  task automatic check_state(input string tag);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput({tag, "_x"}, $signed(dut.x_q[i]), mx[i]);
      checkOutput({tag, "_gap"}, 32'(dut.gap_q[i]), mgap[i]);
    end
    checkOutput({tag, "_passed"}, 32'(passed_cnt), mpassed);
    checkOutput({tag, "_lfsr"}, 32'(dut.lfsr_q), 32'(mlfsr));
  endtask

  vec_t pix_vecs [7];
  vec_t blank_vecs [3];

  initial begin
    pix_vecs[0] = '{11'd700, 11'd50,  1'b0, 12'h123, COL,     1'b1};
    pix_vecs[1] = '{11'd700, 11'd100, 1'b0, 12'h456, 12'h456, 1'b0};
    pix_vecs[2] = '{11'd700, 11'd250, 1'b0, 12'h789, COL,     1'b1};
    pix_vecs[3] = '{11'd750, 11'd50,  1'b0, 12'habc, 12'habc, 1'b0};
    pix_vecs[4] = '{11'd699, 11'd50,  1'b0, 12'hdef, 12'hdef, 1'b0};
    pix_vecs[5] = '{11'd700, 11'd249, 1'b0, 12'h0f0, 12'h0f0, 1'b0};
    pix_vecs[6] = '{11'd700, 11'd50,  1'b1, 12'h321, 12'h000, 1'b0};
    blank_vecs[0] = '{11'd260, 11'd50,  1'b1, 12'h555, 12'h000, 1'b0};
    blank_vecs[1] = '{11'd260, 11'd50,  1'b0, 12'h555, COL,     1'b1};
    blank_vecs[2] = '{11'd260, 11'd250, 1'b0, 12'h555, 12'h555, 1'b0};

    rst = 1'b1;
    enable = 1'b0;
    restart = 1'b0;
    vga_in.hcount = '0; vga_in.vcount = '0; vga_in.hsync = 1'b0; vga_in.vsync = 1'b0;
    vga_in.hblnk = 1'b0; vga_in.vblnk = 1'b0; vga_in.rgb = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset_timing", {vga_out.hcount, vga_out.vcount, vga_out.hsync,
                                 vga_out.vsync, vga_out.hblnk, vga_out.vblnk}, 32'd0);
    checkOutput("reset_rgb", 32'(vga_out.rgb), 32'd0);
    checkOutput("reset_pix", 32'(obst_pix), 32'd0);
    checkOutput("reset_passed", 32'(passed_cnt), 32'd0);
    rst = 1'b0;

    run_frames(1, -1);
    check_state("frozen");
    checkOutput("frozen_x0", $signed(dut.x_q[0]), 32'd800);
    checkOutput("frozen_gap2", 32'(dut.gap_q[2]), 32'd300);

    enable = 1'b1;
    run_frames(50, -1);
    check_state("f50");
    checkOutput("f50_x0", $signed(dut.x_q[0]), 32'd700);
    for (int k = 0; k < 7; k++)
      applyStimulus(pix_vecs[k].h, pix_vecs[k].v, pix_vecs[k].hb, 1'b0, pix_vecs[k].rgb_in,
                    1'b0, 1'b1, pix_vecs[k].exp_rgb, pix_vecs[k].exp_pix);

    run_frames(375, -1);
    check_state("f425");
    checkOutput("respawn_x0", $signed(dut.x_q[0]), 32'd850);
    checkOutput("respawn_x1", $signed(dut.x_q[1]), 32'd250);
    checkOutput("respawn_passed", 32'(passed_cnt), 32'd1);
    for (int k = 0; k < 3; k++)
      applyStimulus(blank_vecs[k].h, blank_vecs[k].v, blank_vecs[k].hb, 1'b0,
                    blank_vecs[k].rgb_in, 1'b0, 1'b1, blank_vecs[k].exp_rgb,
                    blank_vecs[k].exp_pix);

    run_frames(200, 199);
    check_state("restart");
    checkOutput("restart_x0", $signed(dut.x_q[0]), 32'd800);
    checkOutput("restart_x2", $signed(dut.x_q[2]), 32'd1400);
    checkOutput("restart_passed", 32'(passed_cnt), 32'd0);
    checkOutput("lfsr_not_reloaded", 32'(dut.lfsr_q != SEED), 32'd1);

    run_frames(300, -1);
    applyStimulus(11'd400, 11'd300, 1'b0, 1'b0, 12'h abc, 1'b0, 1'b0, 12'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    model_reset();
    checkOutput("async_timing", {vga_out.hcount, vga_out.vcount, vga_out.hsync,
                                 vga_out.vsync, vga_out.hblnk, vga_out.vblnk}, 32'd0);
    checkOutput("async_rgb", 32'(vga_out.rgb), 32'd0);
    checkOutput("async_pix", 32'(obst_pix), 32'd0);
    checkOutput("async_passed", 32'(passed_cnt), 32'd0);
    checkOutput("async_x0", $signed(dut.x_q[0]), 32'd800);
    checkOutput("async_gap1", 32'(dut.gap_q[1]), 32'd200);
    checkOutput("async_lfsr", 32'(dut.lfsr_q), 32'(SEED));
    @(negedge clk);
    rst = 1'b0;

    enable = 1'b0;
    run_frames(1, -1);
    check_state("rerun_frozen");
    enable = 1'b1;
    run_frames(1, -1);
    check_state("rerun_step");
    checkOutput("rerun_x0", $signed(dut.x_q[0]), 32'd798);
    applyStimulus(11'd10, 11'd10, 1'b0, 1'b0, 12'h1a2, 1'b0, 1'b0, 12'h0, 1'b0);
    applyStimulus(11'd10, 11'd10, 1'b0, 1'b0, 12'h1a2, 1'b0, 1'b0, 12'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
